// File: rtl/pc_target_unit.sv
// PC / branch-target unit: program counter, latched branch target and a circular
// return-address stack, updated on the multicycle controller's PC write strobe.
module pc_target_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      OFF_W     = 16,
    parameter int unsigned      SHIFT     = 2,
    parameter int unsigned      STEP      = 4,
    parameter int unsigned      RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_we,
    input  logic [2:0]       mode,
    input  logic [OFF_W-1:0] offset,
    input  logic [WIDTH-1:0] reg_target,
    input  logic             tgt_latch,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] target,
    output logic             misaligned,
    output logic             wrap,
    output logic             ras_full,
    output logic             ras_empty,
    output logic             ras_uflow
);

    localparam int unsigned  PTR_W        = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] RAS_FULL_CNT = (PTR_W + 1)'(RAS_DEPTH);
    localparam logic [WIDTH:0] STEP_EXT   = (WIDTH + 1)'(STEP);

    localparam logic [2:0] MODE_SEQ    = 3'd0;
    localparam logic [2:0] MODE_BRANCH = 3'd1;
    localparam logic [2:0] MODE_JUMP   = 3'd2;
    localparam logic [2:0] MODE_REG    = 3'd3;
    localparam logic [2:0] MODE_CALL   = 3'd4;
    localparam logic [2:0] MODE_RET    = 3'd5;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             misaligned_q, misaligned_d;
    logic             wrap_q, wrap_d;
    logic             uflow_q, uflow_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];

    logic [WIDTH:0]   seq_sum;
    logic [WIDTH:0]   tgt_sum;
    logic [WIDTH-1:0] off_ext;
    logic [PTR_W-1:0] pop_ptr;

    always_comb begin
        seq_sum = {1'b0, pc_q} + STEP_EXT;
        off_ext = {{(WIDTH - OFF_W){offset[OFF_W-1]}}, offset} << SHIFT;
        tgt_sum = {1'b0, pc_q} + {1'b0, off_ext};
        pop_ptr = ptr_q - PTR_W'(1);

        pc_d     = pc_q;
        target_d = target_q;
        wrap_d   = 1'b0;
        uflow_d  = uflow_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        ras_d    = ras_q;

        // A negative offset wraps when the unsigned add does NOT carry (borrow past 0).
        if (tgt_latch) begin
            target_d = tgt_sum[WIDTH-1:0];
            wrap_d   = tgt_sum[WIDTH] ^ offset[OFF_W-1];
        end

        if (pc_we) begin
            case (mode)
                MODE_SEQ: begin
                    pc_d   = seq_sum[WIDTH-1:0];
                    wrap_d = wrap_d | seq_sum[WIDTH];
                end
                MODE_BRANCH: pc_d = target_q;
                MODE_JUMP:   pc_d = {pc_q[WIDTH-1:OFF_W+SHIFT], offset, {SHIFT{1'b0}}};
                MODE_REG:    pc_d = reg_target;
                MODE_CALL: begin
                    pc_d         = target_q;
                    ras_d[ptr_q] = seq_sum[WIDTH-1:0];
                    ptr_d        = ptr_q + PTR_W'(1);
                    wrap_d       = wrap_d | seq_sum[WIDTH];
                    // When full, the push lands on the oldest slot and the count saturates.
                    if (cnt_q != RAS_FULL_CNT) begin
                        cnt_d = cnt_q + (PTR_W + 1)'(1);
                    end
                end
                MODE_RET: begin
                    if (cnt_q != '0) begin
                        pc_d  = ras_q[pop_ptr];
                        ptr_d = pop_ptr;
                        cnt_d = cnt_q - (PTR_W + 1)'(1);
                    end else begin
                        pc_d    = reg_target;
                        uflow_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        misaligned_d = |pc_d[SHIFT-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            target_q     <= '0;
            misaligned_q <= |RESET_PC[SHIFT-1:0];
            wrap_q       <= 1'b0;
            uflow_q      <= 1'b0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            ras_q        <= '{default: '0};
        end else begin
            pc_q         <= pc_d;
            target_q     <= target_d;
            misaligned_q <= misaligned_d;
            wrap_q       <= wrap_d;
            uflow_q      <= uflow_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            ras_q        <= ras_d;
        end
    end

    assign pc         = pc_q;
    assign target     = target_q;
    assign misaligned = misaligned_q;
    assign wrap       = wrap_q;
    assign ras_uflow  = uflow_q;
    assign ras_full   = (cnt_q == RAS_FULL_CNT);
    assign ras_empty  = (cnt_q == '0);

endmodule
